// File: rtl/general_purpose_input_pkg.sv
// Shared constants and helpers for the general-purpose input port.
//
// Contents:
//   DEFAULT_WIDTH            default number of pins (8)
//   DEFAULT_DEBOUNCE_CYCLES  default debounce hold time in cycles (16)
//   cnt_width()              width of a per-pin debounce counter, never below 1
package general_purpose_input_pkg;

  localparam int DEFAULT_WIDTH           = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // $clog2(1) is 0, so a single-cycle debounce still needs a 1-bit counter.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpi_debounce.sv
// One pin of the general-purpose input port: two-flop synchroniser followed
// by a hold-time debouncer.
//
// Ports:
//   clk     clock
//   rst_n   synchronous active-low reset
//   pin     raw asynchronous pin
//   stable  debounced level (register)
//   rise    high in the cycle whose closing edge takes stable from 0 to 1,
//           so a flag captured on that edge lines up with the stable update
module gpi_debounce
  import general_purpose_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // The synchronised level has differed from stable for DEBOUNCE_CYCLES
  // consecutive edges, counting this one; stable takes it on this edge.
  assign accept = (s2 != stable) && !(cnt < CNT_MAX);
  assign rise   = accept && s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == stable) begin
        // Any return to the accepted level throws away a partial count.
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/general_purpose_input.sv
// Memory-mapped general-purpose input port. Each pin is synchronised and
// debounced independently; the debounced levels are presented on a Decoupled
// sender and rising edges latch sticky flags that the CPU clears with a
// write-1-to-clear mask on a Decoupled receiver.
//
// Ports:
//   i_clk          clock (single domain)
//   i_rst_n        synchronous active-low reset
//   if_din_valid   clear-mask beat valid
//   if_din_ready   always 1: every valid clear beat is accepted
//   if_din_bits    clear mask, 1 clears the matching flag
//   if_dout_valid  always 1: the debounced levels are always available
//   if_dout_ready  consumer ready (levels are not consumed, so ignored)
//   if_dout_bits   debounced pin levels
//   i_gpin         raw asynchronous pins
//   o_edge         sticky rising-edge flags
//   o_irq          OR of o_edge, combinational from the flag register
//
// Handshake: a beat transfers on a clock edge where valid and ready are both
// high; bits are meaningful only while valid is high. Both ports here tie
// their own side of the handshake high, so the receiver accepts every valid
// beat and the sender offers a fresh value every cycle.
module general_purpose_input
  import general_purpose_input_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             if_din_valid,
  output logic             if_din_ready,
  input  logic [WIDTH-1:0] if_din_bits,
  output logic             if_dout_valid,
  input  logic             if_dout_ready,
  output logic [WIDTH-1:0] if_dout_bits,
  input  logic [WIDTH-1:0] i_gpin,
  output logic [WIDTH-1:0] o_edge,
  output logic             o_irq
);

  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] clr_mask;
  logic             unused_dout_ready;

  assign unused_dout_ready = if_dout_ready;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpi_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .pin    (i_gpin[i]),
      .stable (stable_vec[i]),
      .rise   (rise_vec[i])
    );
  end

  assign if_din_ready  = 1'b1;
  assign if_dout_valid = 1'b1;
  assign if_dout_bits  = stable_vec;

  assign clr_mask = if_din_valid ? if_din_bits : '0;

  // Clear is applied before set so a rise on the same edge as a clear wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_edge <= '0;
    end else begin
      o_edge <= (o_edge & ~clr_mask) | rise_vec;
    end
  end

  assign o_irq = |o_edge;

endmodule
